tt_um_onehot_encoder: RTL and testbench
=======================================

TT_UM_ONEHOT_ENCODER -- requirements
Module: tt_um_onehot_encoder

Interface
REQ-001 SHALL have one clock, `clk`, input, 1 bit; all state updates on its rising edge.
REQ-002 SHALL have `rst_n`, input, 1 bit; reset is asynchronous and active-low.
REQ-003 SHALL have `ena`, input, 1 bit; high = design enabled; low = all state frozen.
REQ-004 SHALL have `ui_in`, input, 8 bits; raw one-hot code from switches, asynchronous to `clk`.
REQ-005 SHALL have `uio_in`, input, 8 bits: [0] = `clr` (clears error state); [2:1] = `win_sel` (stability window); [7:3] = ignored.
REQ-006 SHALL have `uo_out`, output, 8 bits: [2:0] = `idx`, [3] = `valid`, [4] = `zero`, [5] = `multi`, [6] = `chg` pulse, [7] = `err` (sticky).
REQ-007 SHALL have `uio_out`, output, 8 bits: [7:4] = `err_cnt`; [3:0] = 0.
REQ-008 SHALL have `uio_oe`, output, 8 bits, driven to the constant 8'hF0.

Function
REQ-009 SHALL pass `ui_in` through a 2-flop synchronizer (`s1` then `s2`) before any use.
REQ-010 SHALL register `prev` <= `s2` every enabled edge and keep an 8-bit stability counter `cnt`.
- `cnt` -> 0 when `s2` != `prev`.
- Otherwise `cnt` increments, saturating at 255.
REQ-011 SHALL set window N from `win_sel`: 00 = 4, 01 = 16, 10 = 64, 11 = 255; `win_sel` is sampled live.
REQ-012 SHALL use an FSM with states SETTLE and HOLD.
- SETTLE -> HOLD when `cnt` == N with `s2` == `prev`; this is the acceptance event.
- HOLD -> SETTLE when `s2` != `prev`.
- Reset state is SETTLE.
REQ-013 SHALL raise acceptance exactly once per stable value; re-acceptance requires passing through SETTLE.
REQ-014 SHALL register outputs on the edge after acceptance, so a value first sampled into `s1` at edge 0 appears on `uo_out` after edge N+3.
REQ-015 SHALL classify on acceptance:
- Exactly one bit k set: `valid` = 1, `idx` = k, `zero` = 0, `multi` = 0.
- No bits set: `zero` = 1, `valid` = 0, `multi` = 0, `idx` held.
- Two or more bits set: `multi` = 1, `valid` = 0, `zero` = 0, `idx` held.
REQ-016 SHALL hold classification outputs unchanged in SETTLE; glitches shorter than N+1 cycles are never reported.
REQ-017 SHALL pulse `chg` high for exactly one cycle at an output update with `valid` = 1 whose `idx` differs from the last valid `idx`, or that is the first valid since reset.
REQ-018 SHALL on a `multi` acceptance set `err` = 1 and increment `err_cnt` by 1, saturating at 15.
REQ-019 SHALL on a `clr` sample of 1 synchronously zero `err` and `err_cnt`; `clr` wins over a simultaneous increment; `clr` does not affect other outputs.
REQ-020 SHALL, while `ena` = 0, hold `s1`, `s2`, `prev`, `cnt`, FSM and all outputs, force `chg` = 0, and resume counting from the held `cnt`.
REQ-021 SHALL ignore `uio_in[7:3]`.

Reset
REQ-022 SHALL on `rst_n` low immediately clear `s1`, `s2`, `prev`, `cnt`, `err_cnt` to 0, FSM to SETTLE, `uo_out` to 8'h00 and `uio_out` to 8'h00.
REQ-023 SHALL treat a reset asserted mid-window as discarding the window.
- No partial acceptance.
- After release, a constant input is accepted N+3 edges after the first sampling edge.
REQ-024 SHALL keep `uio_oe` = 8'hF0 during and after reset.

Structure
REQ-025 SHALL place the following in shared package `onehot_pkg`: FSM state enum (SETTLE, HOLD), window constants (4/16/64/255), ERR_MAX = 15, and `uo_out` bit-position constants.
REQ-026 SHALL implement synchronizer, `prev` and `cnt` as one sub-module `onehot_sync_filter`, outputting the stable value and an accept strobe.
REQ-027 SHALL keep classification, `chg`, error logic and the FSM in the top module.

Verification
REQ-028 Valid code: `win_sel` = 00, `ui_in` = 8'h20 held -> after edge 7 `uo_out` = 8'h4D (`idx` 5, `valid`, `chg`); next cycle `uo_out` = 8'h0D.
REQ-029 Glitch rejection: accepted 8'h20, then 8'h01 for 3 cycles, then back to 8'h20 -> `uo_out` stays 8'h0D, no `chg` pulse.
REQ-030 Multi code: `ui_in` = 8'h03 held -> `uo_out[5]` = 1, `uo_out[7]` = 1, `err_cnt` = 1; repeat 16 distinct multi acceptances -> `err_cnt` = 15 (saturated).
REQ-031 Clear precedence: `clr` = 1 on the edge of a multi acceptance -> `err` = 0, `err_cnt` = 0, `multi` = 1.
REQ-032 Zero and reset: `ui_in` = 8'h00 held -> `uo_out` = 8'h10; `rst_n` low mid-window -> `uo_out` = 8'h00 immediately, acceptance N+3 edges after release.
REQ-033 Enable and window: `ena` = 0 for 10 cycles mid-window -> no output change; `win_sel` = 11 -> acceptance at edge 258.

Source files
------------

// File: rtl/onehot_pkg.sv
// Shared definitions for the one-hot switch encoder: FSM states, stability
// windows, error counter limit and the bit layout of uo_out.
package onehot_pkg;

    typedef enum logic {
        SETTLE = 1'b0,
        HOLD   = 1'b1
    } state_t;

    localparam logic [7:0] WIN_4   = 8'd4;
    localparam logic [7:0] WIN_16  = 8'd16;
    localparam logic [7:0] WIN_64  = 8'd64;
    localparam logic [7:0] WIN_255 = 8'd255;

    localparam logic [3:0] ERR_MAX = 4'd15;

    localparam int UO_IDX_LSB = 0;
    localparam int UO_VALID   = 3;
    localparam int UO_ZERO    = 4;
    localparam int UO_MULTI   = 5;
    localparam int UO_CHG     = 6;
    localparam int UO_ERR     = 7;

    // Translate the two window-select switches into a stability length.
    function automatic logic [7:0] winFromSel(input logic [1:0] sel);
        logic [7:0] win;
        case (sel)
            2'b00:   win = WIN_4;
            2'b01:   win = WIN_16;
            2'b10:   win = WIN_64;
            default: win = WIN_255;
        endcase
        return win;
    endfunction

    // Number of switches that are on.
    function automatic logic [3:0] countOnes(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    // Position of the highest set switch; only meaningful for a one-hot code.
    function automatic logic [2:0] highIndex(input logic [7:0] v);
        logic [2:0] k;
        k = '0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) begin
                k = 3'(i);
            end
        end
        return k;
    endfunction

endpackage

// File: rtl/onehot_sync_filter.sv
// Brings the asynchronous switch code into the clock domain and measures how
// long the synchronized value has stayed put. Raises o_accept while the value
// has been steady for exactly the selected window.
module onehot_sync_filter
    import onehot_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_ena,
    input  logic [7:0] i_raw,
    input  logic [7:0] i_win,
    output logic [7:0] o_stable,
    output logic       o_accept,
    output logic       o_change
);

    logic [7:0] r_s1;
    logic [7:0] r_s2;
    logic [7:0] r_prev;
    logic [7:0] r_cnt;
    logic [2:0] r_fill;
    logic       w_same;

    // The reset contents of s1/s2/prev are not real samples, so r_fill marks
    // which stages hold switch data; a steady zero input is timed exactly like
    // any other code after reset instead of inheriting the cleared pipeline.
    assign w_same = (r_s2 == r_prev) && r_fill[2];

    // Synchronizer, previous-sample register and saturating stability counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_prev <= '0;
            r_cnt  <= '0;
            r_fill <= '0;
        end else if (i_ena) begin
            r_s1   <= i_raw;
            r_s2   <= r_s1;
            r_prev <= r_s2;
            r_fill <= {r_fill[1:0], 1'b1};
            if (!w_same) begin
                r_cnt <= '0;
            end else if (r_cnt != WIN_255) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    assign o_stable = r_s2;
    assign o_accept = w_same && (r_cnt == i_win);
    assign o_change = (r_s2 != r_prev);

endmodule

// File: rtl/tt_um_onehot_encoder.sv
// One-hot switch encoder: debounces an 8-switch code, reports the index of a
// single active switch, flags empty or multiple-switch codes, pulses on a new
// index and keeps a sticky error flag with a saturating error count.
module tt_um_onehot_encoder
    import onehot_pkg::*;
(
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    logic [7:0] w_win;
    logic       w_clr;
    logic       w_unused;
    logic [7:0] w_stable;
    logic       w_accept;
    logic       w_change;

    state_t     r_state;
    state_t     w_nextState;
    logic       w_acceptEvt;

    logic [3:0] w_ones;
    logic [2:0] w_k;
    logic       w_isOne;
    logic       w_isZero;
    logic       w_isMulti;
    logic       w_chgNext;

    logic [2:0] r_idx;
    logic       r_valid;
    logic       r_zero;
    logic       r_multi;
    logic       r_chg;
    logic       r_err;
    logic [3:0] r_errCnt;
    logic       r_haveValid;

    assign w_win    = winFromSel(uio_in[2:1]);
    assign w_clr    = uio_in[0];
    assign w_unused = &{1'b0, uio_in[7:3]};

    onehot_sync_filter u_filter (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_ena    (ena),
        .i_raw    (ui_in),
        .i_win    (w_win),
        .o_stable (w_stable),
        .o_accept (w_accept),
        .o_change (w_change)
    );

    // FSM state register; frozen while the design is disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SETTLE;
        end else if (ena) begin
            r_state <= w_nextState;
        end
    end

    // Accept a steady value once, then wait in HOLD until the input moves.
    always_comb begin
        w_nextState = r_state;
        w_acceptEvt = 1'b0;
        case (r_state)
            SETTLE: begin
                if (w_accept) begin
                    w_nextState = HOLD;
                    w_acceptEvt = 1'b1;
                end
            end
            HOLD: begin
                if (w_change) begin
                    w_nextState = SETTLE;
                end
            end
            default: w_nextState = SETTLE;
        endcase
    end

    // Classify the accepted code and decide whether it is a new valid index.
    always_comb begin
        w_ones    = countOnes(w_stable);
        w_k       = highIndex(w_stable);
        w_isOne   = (w_ones == 4'd1);
        w_isZero  = (w_ones == 4'd0);
        w_isMulti = (w_ones > 4'd1);
        w_chgNext = w_acceptEvt && w_isOne && (!r_haveValid || (w_k != r_idx));
    end

    // Output registers: classification on acceptance, change pulse, and the
    // error flag/count where clear takes priority over a new error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx       <= '0;
            r_valid     <= 1'b0;
            r_zero      <= 1'b0;
            r_multi     <= 1'b0;
            r_chg       <= 1'b0;
            r_err       <= 1'b0;
            r_errCnt    <= '0;
            r_haveValid <= 1'b0;
        end else if (ena) begin
            r_chg <= w_chgNext;
            if (w_acceptEvt) begin
                r_valid <= w_isOne;
                r_zero  <= w_isZero;
                r_multi <= w_isMulti;
                if (w_isOne) begin
                    r_idx       <= w_k;
                    r_haveValid <= 1'b1;
                end
            end
            if (w_clr) begin
                r_err    <= 1'b0;
                r_errCnt <= '0;
            end else if (w_acceptEvt && w_isMulti) begin
                r_err <= 1'b1;
                if (r_errCnt != ERR_MAX) begin
                    r_errCnt <= r_errCnt + 4'd1;
                end
            end
        end else begin
            r_chg <= 1'b0;
        end
    end

    // Pack the status bits; the change pulse is masked while disabled.
    always_comb begin
        uo_out                     = '0;
        uo_out[UO_IDX_LSB +: 3]    = r_idx;
        uo_out[UO_VALID]           = r_valid;
        uo_out[UO_ZERO]            = r_zero;
        uo_out[UO_MULTI]           = r_multi;
        uo_out[UO_CHG]             = r_chg & ena;
        uo_out[UO_ERR]             = r_err;
    end

    assign uio_out = {r_errCnt, 4'b0000};
    assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_onehot_encoder.sv
// Self-checking bench for the one-hot encoder: a sampler turns the driven
// switch history into expected acceptances, a monitor applies them to a
// behavioural output model and compares every cycle.
module tb_tt_um_onehot_encoder;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       ena    = 1'b1;
    logic [7:0] ui_in  = 8'h20;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int         due;
        logic [7:0] code;
    } exp_t;

    exp_t       sbQueue[$];
    int         enEdges    = 0;
    int         runLen     = 0;
    logic [7:0] lastSample = 8'h00;

    logic       expValid   = 1'b0;
    logic       expZero    = 1'b0;
    logic       expMulti   = 1'b0;
    logic       expChg     = 1'b0;
    logic       expErr     = 1'b0;
    logic [2:0] expIdx     = 3'd0;
    int         expErrCnt  = 0;
    logic       haveValid  = 1'b0;

    always #5 clk = ~clk;

    tt_um_onehot_encoder dut (
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe),
        .ena     (ena),
        .clk     (clk),
        .rst_n   (rst_n)
    );

    function automatic int windowOf(input logic [1:0] sel);
        case (sel)
            2'b00:   return 4;
            2'b01:   return 16;
            2'b10:   return 64;
            default: return 255;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%02h expected=%02h at t=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic stepCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [7:0] code, input int n);
        ui_in = code;
        stepCycles(n);
    endtask

    task automatic applyReset();
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("reset_uo_out", uo_out, 8'h00);
        checkOutput("reset_uio_out", uio_out, 8'h00);
        checkOutput("reset_uio_oe", uio_oe, 8'hF0);
        stepCycles(2);
        rst_n = 1'b1;
    endtask

    // Sampler: a code is accepted once it has been sampled on N+2 consecutive
    // enabled edges; the outputs show it two enabled edges later.
    initial forever begin
        @(posedge clk);
        if (!rst_n) begin
            sbQueue.delete();
            runLen = 0;
        end else if (ena) begin
            enEdges++;
            if (runLen != 0 && ui_in == lastSample) begin
                runLen++;
            end else begin
                runLen     = 1;
                lastSample = ui_in;
            end
            if (runLen == windowOf(uio_in[2:1]) + 2) begin
                sbQueue.push_back('{due: enEdges + 2, code: ui_in});
            end
        end
    end

    // Monitor: updates the expected outputs from due acceptances and clears,
    // then compares all outputs once per cycle.
    initial forever begin
        logic       edgeEna;
        logic       edgeClr;
        logic       edgeRst;
        logic [7:0] code;
        int         k;
        @(posedge clk);
        edgeEna = ena;
        edgeClr = uio_in[0];
        edgeRst = rst_n;
        #1;
        if (!edgeRst) begin
            expValid  = 1'b0;
            expZero   = 1'b0;
            expMulti  = 1'b0;
            expChg    = 1'b0;
            expErr    = 1'b0;
            expIdx    = 3'd0;
            expErrCnt = 0;
            haveValid = 1'b0;
        end else if (!edgeEna) begin
            expChg = 1'b0;
        end else begin
            expChg = 1'b0;
            while (sbQueue.size() > 0 && sbQueue[0].due < enEdges) begin
                checks++;
                failures++;
                $display("[TB] FAIL sb_stale due=%0d now=%0d", sbQueue[0].due, enEdges);
                void'(sbQueue.pop_front());
            end
            if (sbQueue.size() > 0 && sbQueue[0].due == enEdges) begin
                code = sbQueue.pop_front().code;
                if ($countones(code) == 1) begin
                    k        = $clog2(code);
                    expChg   = !haveValid || (k != int'(expIdx));
                    expIdx   = 3'(k);
                    haveValid = 1'b1;
                    expValid = 1'b1;
                    expZero  = 1'b0;
                    expMulti = 1'b0;
                end else if (code == 8'h00) begin
                    expValid = 1'b0;
                    expZero  = 1'b1;
                    expMulti = 1'b0;
                end else begin
                    expValid = 1'b0;
                    expZero  = 1'b0;
                    expMulti = 1'b1;
                    expErr   = 1'b1;
                    if (expErrCnt < 15) expErrCnt++;
                end
            end
            if (edgeClr) begin
                expErr    = 1'b0;
                expErrCnt = 0;
            end
        end
        checkOutput("mon_uo_out", uo_out, {expErr, expChg, expMulti, expZero, expValid, expIdx});
        checkOutput("mon_uio_out", uio_out, {4'(expErrCnt), 4'h0});
        checkOutput("mon_uio_oe", uio_oe, 8'hF0);
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [7:0] v;
        int         n;
        #1;
        checkOutput("init_uo_out", uo_out, 8'h00);
        checkOutput("init_uio_out", uio_out, 8'h00);
        checkOutput("init_uio_oe", uio_oe, 8'hF0);
        stepCycles(2);
        rst_n = 1'b1;

        // Valid code with the shortest window.
        stepCycles(7);
        checkOutput("valid_early", uo_out, 8'h00);
        stepCycles(1);
        checkOutput("valid_accept", uo_out, 8'h4D);
        stepCycles(1);
        checkOutput("valid_after", uo_out, 8'h0D);

        // Short glitch is never reported.
        applyStimulus(8'h01, 3);
        applyStimulus(8'h20, 20);
        checkOutput("glitch_hold", uo_out, 8'h0D);

        // Multiple switches raise the error and saturate the count.
        applyStimulus(8'h03, 10);
        checkOutput("multi_uo", uo_out, 8'hA5);
        checkOutput("multi_cnt", uio_out, 8'h10);
        for (int i = 0; i < 16; i++) begin
            applyStimulus((i % 2 == 0) ? 8'h06 : 8'h03, 8);
        end
        checkOutput("multi_sat", uio_out, 8'hF0);

        // Clear on the very edge of a multi acceptance wins.
        applyStimulus(8'h01, 10);
        applyStimulus(8'h81, 7);
        uio_in[0] = 1'b1;
        stepCycles(1);
        uio_in[0] = 1'b0;
        checkOutput("clr_uo", uo_out, 8'h20);
        checkOutput("clr_cnt", uio_out, 8'h00);

        // Empty code.
        applyStimulus(8'h00, 10);
        checkOutput("zero_uo", uo_out, 8'h10);

        // Reset in the middle of a window.
        applyStimulus(8'h40, 3);
        applyReset();
        stepCycles(7);
        checkOutput("rst_early", uo_out, 8'h00);
        stepCycles(1);
        checkOutput("rst_accept", uo_out, 8'h4E);

        // Disabled cycles in the middle of a window.
        applyStimulus(8'h08, 3);
        ena = 1'b0;
        stepCycles(10);
        checkOutput("ena_frozen", uo_out, 8'h0E);
        ena = 1'b1;
        stepCycles(4);
        checkOutput("ena_early", uo_out, 8'h0E);
        stepCycles(1);
        checkOutput("ena_accept", uo_out, 8'h4B);

        // Longest window.
        uio_in = 8'b0000_0110;
        ui_in  = 8'h10;
        applyReset();
        stepCycles(258);
        checkOutput("win255_early", uo_out, 8'h00);
        stepCycles(1);
        checkOutput("win255_accept", uo_out, 8'h4C);

        // Randomized segments with the two short windows.
        for (int seg = 0; seg < 2; seg++) begin
            uio_in = {5'($urandom), 2'(seg), 1'b0};
            applyReset();
            for (int it = 0; it < 70; it++) begin
                case ($urandom_range(0, 3))
                    0, 1:    v = 8'h01 << $urandom_range(0, 7);
                    2:       v = 8'h00;
                    default: begin
                        v = 8'($urandom);
                        while ($countones(v) < 2) v = 8'($urandom);
                    end
                endcase
                n      = $urandom_range(1, windowOf(2'(seg)) + 6);
                ena    = ($urandom_range(0, 5) != 0);
                uio_in = {5'($urandom), 2'(seg), ($urandom_range(0, 7) == 0)};
                if ($urandom_range(0, 24) == 0) begin
                    applyReset();
                end
                applyStimulus(v, n);
            end
            ena    = 1'b1;
            uio_in[0] = 1'b0;
            stepCycles(30);
        end

        stepCycles(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
